control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents from the datapath
REQ-002 The block SHALL drive these datapath strobes, all 1-bit outputs:
- PCout, PCin, IncPC, MARin
- MDR_read, MDRin, MDRout, IRin, Yin
- Zlow_enable, Zhigh_enable, Zlowout, Zhighout
- LO_enable, HI_enable
REQ-003 The block SHALL have these further outputs:
- op_code  out  5  ALU operation select
- r_in  out  16  register-file load enables, R0..R15
- r_out  out  16  register-file bus drive enables, R0..R15
- run  out  1  high while sequencing
- illegal_op  out  1  one-cycle pulse on an unsupported opcode

Function
REQ-004 IR fields SHALL be: opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
REQ-005 The FSM SHALL have the states RST, T0, T1, T2, T3, T4, T5, T6 and HALT, with one clock per state.
REQ-006 Outputs SHALL be Moore-decoded from the state and ir, and every strobe not listed for a state SHALL be 0.
REQ-007 State actions SHALL be:
- T0: PCout, MARin, IncPC, Zlow_enable.
- T1: Zlowout, PCin, MDR_read, MDRin.
- T2: MDRout, IRin.
REQ-008 For R-format opcodes 3..11 (add, sub, and, or, shr, shra, shl, ror, rol), the execute states SHALL be:
- T3: r_out[rb], Yin.
- T4: r_out[rc], op_code=opcode, Zlow_enable.
- T5: Zlowout, r_in[ra].
- Then go to T0.
REQ-009 For mul (15) and div (16), the execute states SHALL be:
- T3: r_out[ra], Yin.
- T4: r_out[rb], op_code=opcode, Zlow_enable, Zhigh_enable.
- T5: Zlowout, LO_enable.
- T6: Zhighout, HI_enable.
- Then go to T0.
REQ-010 In T3, nop (26) SHALL go directly to T0, and halt (27) SHALL go to HALT.
REQ-011 In T3, any other opcode SHALL pulse illegal_op for that cycle and go to T0, with no register write.
REQ-012 In T3 the decision SHALL use the ir value latched at the end of T2.
REQ-013 op_code SHALL be 0 in every state except T4.
REQ-014 At most one r_out bit SHALL be asserted in any cycle.
REQ-015 r_in SHALL be asserted only in T5 of R-format instructions.
REQ-016 ra=rb=rc SHALL be legal, with no special handling.
REQ-017 T6 SHALL be reachable only from mul or div.
REQ-018 The state encoding SHALL have no unreachable traps: any undefined encoding SHALL go to RST on the next edge.
REQ-019 HALT SHALL persist until reset, with all strobes 0 and run=0.
REQ-020 run SHALL be 1 in T0..T6 and 0 in RST and HALT.

Reset
REQ-021 While reset=1 at a rising edge, the next state SHALL be RST, regardless of the current state, including mid-instruction or in HALT.
REQ-022 In RST, all outputs SHALL be 0, including op_code, r_in, r_out, run and illegal_op.
REQ-023 On the first edge with reset=0, RST SHALL go to T0.
REQ-024 A partially executed instruction SHALL NOT complete after reset.

Structure
REQ-025 Opcode constants (add..rol, mul, div, nop, halt) and state encodings SHALL live in a shared cpu_defs package/include, also used by the ALU and benches.
REQ-026 The ra/rb/rc-to-one-hot conversion SHALL be one sub-module, reg_decode_4to16 (4-bit index plus enable in, 16-bit one-hot out), instantiated for r_in and r_out.
REQ-027 The top level SHALL contain only the state register, next-state logic and strobe decode.

Verification
REQ-028 Reset 2 cycles, then ir=0x489A8000 (shl r1,r3,r5) presented from T2 SHALL give:
- T0..T2 fetch strobes exact per REQ-007.
- T3: r_out=0x0008, Yin=1.
- T4: r_out=0x0020, op_code=01001, Zlow_enable=1.
- T5: r_in=0x0002, Zlowout=1.
- Then T0.
REQ-029 ir=0x79200000 (mul r2,r4) SHALL give:
- T3: r_out=0x0004.
- T4: r_out=0x0010, op_code=01111, Zlow_enable=Zhigh_enable=1.
- T5: LO_enable=1.
- T6: HI_enable=1.
- Then T0; r_in=0 throughout.
REQ-030 ir=0xD8000000 (halt) SHALL give T3 then HALT, with run=0 and all strobes 0 for 10 or more cycles, then reset leads to RST then T0.
REQ-031 ir=0x08000000 (opcode 1, unsupported) SHALL give illegal_op=1 for exactly the T3 cycle, then T0, with r_in never asserted.
REQ-032 reset=1 asserted during T4 of shl SHALL give RST with all outputs 0 on the next edge; T5's r_in write SHALL never occur, and a fresh fetch SHALL begin after reset deasserts.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU definitions.
//   - Opcode constants for the R-format ALU group, mul/div, nop and halt.
//   - Control-unit state encoding (state_e).
//   - Helpers that classify an opcode into its execute-sequence group.
// Ports: none (package).
package cpu_defs_pkg;

   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_e;

   // add..rol form one contiguous opcode range sharing a three-step execute.
   function automatic logic is_rfmt(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_ROL);
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/reg_decode_4to16.sv
// reg_decode_4to16: register index to one-hot enable decoder.
// Ports:
//   idx_i    in  4   register index R0..R15
//   en_i     in  1   output is all-zero when low
//   onehot_o out 16  one-hot select, bit idx_i set when enabled
module reg_decode_4to16 (
   input  logic [3:0]  idx_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   assign onehot_o = en_i ? (16'h0001 << idx_i) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle CPU sequencer (fetch T0..T2, execute T3..T6).
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   ir[31:0]           instruction register contents from the datapath
//   PCout..HI_enable   1-bit datapath strobes
//   op_code[4:0]       ALU operation select, non-zero only in T4
//   r_in/r_out[15:0]   register-file load / bus-drive enables
//   run                high in T0..T6
//   illegal_op         one-cycle pulse in T3 on an unsupported opcode
// Outputs are a Moore decode of the state register and the current ir.
module control_unit
   import cpu_defs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDR_read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlow_enable,
   output logic        Zhigh_enable,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        LO_enable,
   output logic        HI_enable,
   output logic [4:0]  op_code,
   output logic [15:0] r_in,
   output logic [15:0] r_out,
   output logic        run,
   output logic        illegal_op
);

   state_e     state_q, state_d;
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       rfmt, muldiv;
   logic [3:0] rout_idx;
   logic       rout_en, rin_en;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];
   assign rfmt      = is_rfmt(opcode);
   assign muldiv    = is_muldiv(opcode);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_RST;
      else       state_q <= state_d;
   end

   // Reset is also folded in here so the next-state value alone tells
   // where the machine goes; undefined encodings fall back to RST.
   always_comb begin
      state_d = ST_RST;
      case (state_q)
         ST_RST:  state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = ST_T2;
         ST_T2:   state_d = ST_T3;
         ST_T3: begin
            if (rfmt || muldiv)        state_d = ST_T4;
            else if (opcode == OP_HALT) state_d = ST_HALT;
            else                        state_d = ST_T0;
         end
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = muldiv ? ST_T6 : ST_T0;
         ST_T6:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RST;
      endcase
      if (reset) state_d = ST_RST;
   end

   always_comb begin
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
      MDR_read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
      Yin = 1'b0; Zlow_enable = 1'b0; Zhigh_enable = 1'b0;
      Zlowout = 1'b0; Zhighout = 1'b0; LO_enable = 1'b0; HI_enable = 1'b0;
      op_code = 5'd0; run = 1'b0; illegal_op = 1'b0;
      rout_idx = 4'd0; rout_en = 1'b0; rin_en = 1'b0;
      case (state_q)
         ST_T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlow_enable = 1'b1;
         end
         ST_T1: begin
            run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; MDR_read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            run = 1'b1;
            // mul/div put ra on the bus first; R-format uses rb.
            if (rfmt) begin
               rout_idx = rb; rout_en = 1'b1; Yin = 1'b1;
            end else if (muldiv) begin
               rout_idx = ra; rout_en = 1'b1; Yin = 1'b1;
            end else if ((opcode != OP_NOP) && (opcode != OP_HALT)) begin
               illegal_op = 1'b1;
            end
         end
         ST_T4: begin
            run = 1'b1;
            if (rfmt) begin
               rout_idx = rc; rout_en = 1'b1; op_code = opcode; Zlow_enable = 1'b1;
            end else if (muldiv) begin
               rout_idx = rb; rout_en = 1'b1; op_code = opcode;
               Zlow_enable = 1'b1; Zhigh_enable = 1'b1;
            end
         end
         ST_T5: begin
            run = 1'b1;
            if (rfmt) begin
               Zlowout = 1'b1; rin_en = 1'b1;
            end else if (muldiv) begin
               Zlowout = 1'b1; LO_enable = 1'b1;
            end
         end
         ST_T6: begin
            run = 1'b1; Zhighout = 1'b1; HI_enable = 1'b1;
         end
         default: ;
      endcase
   end

   reg_decode_4to16 u_rin_dec (
      .idx_i    (ra),
      .en_i     (rin_en),
      .onehot_o (r_in)
   );

   reg_decode_4to16 u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (r_out)
   );

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against a cycle-list
// reference model of the control unit's fetch/execute sequences.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ir = 32'd0;
   logic PCout, PCin, IncPC, MARin, MDR_read, MDRin, MDRout, IRin, Yin;
   logic Zlow_enable, Zhigh_enable, Zlowout, Zhighout, LO_enable, HI_enable;
   logic [4:0]  op_code;
   logic [15:0] r_in, r_out;
   logic        run, illegal_op;

   typedef logic [53:0] obs_t;
   obs_t obs;
   obs_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   localparam logic [14:0] S_PCOUT = 15'h4000, S_PCIN  = 15'h2000, S_INCPC = 15'h1000;
   localparam logic [14:0] S_MARIN = 15'h0800, S_MDRRD = 15'h0400, S_MDRIN = 15'h0200;
   localparam logic [14:0] S_MDROUT = 15'h0100, S_IRIN = 15'h0080, S_YIN   = 15'h0040;
   localparam logic [14:0] S_ZLEN  = 15'h0020, S_ZHEN  = 15'h0010, S_ZLOUT = 15'h0008;
   localparam logic [14:0] S_ZHOUT = 15'h0004, S_LOEN  = 15'h0002, S_HIEN  = 15'h0001;

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .reset(reset), .ir(ir),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .MDR_read(MDR_read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .Zlow_enable(Zlow_enable), .Zhigh_enable(Zhigh_enable),
      .Zlowout(Zlowout), .Zhighout(Zhighout),
      .LO_enable(LO_enable), .HI_enable(HI_enable),
      .op_code(op_code), .r_in(r_in), .r_out(r_out),
      .run(run), .illegal_op(illegal_op)
   );

   assign obs = {PCout, PCin, IncPC, MARin, MDR_read, MDRin, MDRout, IRin, Yin,
                 Zlow_enable, Zhigh_enable, Zlowout, Zhighout, LO_enable, HI_enable,
                 op_code, r_in, r_out, run, illegal_op};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected output word for one cycle of a running (T0..T6) state.
   function automatic obs_t mk(input logic [14:0] s, input logic [4:0] op,
                               input logic [15:0] rin, input logic [15:0] rout,
                               input logic ill);
      return {s, op, rin, rout, 1'b1, ill};
   endfunction

   function automatic logic [15:0] sel(input logic [3:0] i);
      logic [15:0] one;
      one = 16'd1;
      return one << i;
   endfunction

   // Reference model: push the full cycle-by-cycle output list for one instruction.
   task automatic model_instr(input logic [31:0] iv);
      logic [4:0] opc;
      logic [3:0] ra, rb, rc;
      opc = iv[31:27]; ra = iv[26:23]; rb = iv[22:19]; rc = iv[18:15];
      exp_q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZLEN, 5'd0, 16'd0, 16'd0, 1'b0));
      exp_q.push_back(mk(S_ZLOUT | S_PCIN | S_MDRRD | S_MDRIN, 5'd0, 16'd0, 16'd0, 1'b0));
      exp_q.push_back(mk(S_MDROUT | S_IRIN, 5'd0, 16'd0, 16'd0, 1'b0));
      if (opc >= 5'd3 && opc <= 5'd11) begin
         exp_q.push_back(mk(S_YIN, 5'd0, 16'd0, sel(rb), 1'b0));
         exp_q.push_back(mk(S_ZLEN, opc, 16'd0, sel(rc), 1'b0));
         exp_q.push_back(mk(S_ZLOUT, 5'd0, sel(ra), 16'd0, 1'b0));
      end else if (opc == 5'd15 || opc == 5'd16) begin
         exp_q.push_back(mk(S_YIN, 5'd0, 16'd0, sel(ra), 1'b0));
         exp_q.push_back(mk(S_ZLEN | S_ZHEN, opc, 16'd0, sel(rb), 1'b0));
         exp_q.push_back(mk(S_ZLOUT | S_LOEN, 5'd0, 16'd0, 16'd0, 1'b0));
         exp_q.push_back(mk(S_ZHOUT | S_HIEN, 5'd0, 16'd0, 16'd0, 1'b0));
      end else if (opc == 5'd26 || opc == 5'd27) begin
         exp_q.push_back(mk(15'd0, 5'd0, 16'd0, 16'd0, 1'b0));
      end else begin
         exp_q.push_back(mk(15'd0, 5'd0, 16'd0, 16'd0, 1'b1));
      end
   endtask

   // One clock: inputs already applied; sample mid-cycle, then advance past the edge.
   task automatic cycle(input obs_t e, input string tag);
      @(negedge clk);
      check_val(tag, obs, e);
      check_val({tag, "_rout_onehot0"}, 64'($onehot0(r_out)), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction. ir carries garbage in T0/T1 and the instruction from
   // T2 on. abort_at >= 0 raises reset during that cycle index.
   task automatic do_instr(input logic [31:0] iv, input int abort_at, input int id,
                           output bit aborted);
      int   k;
      obs_t e;
      aborted = 1'b0;
      model_instr(iv);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         ir = (k < 2) ? $urandom : iv;
         if (k == abort_at) reset = 1'b1;
         cycle(e, $sformatf("i%0d_ir%h_c%0d", id, iv, k));
         if (k == abort_at) begin
            reset = 1'b0;
            cycle(obs_t'(0), $sformatf("i%0d_rst_after_abort", id));
            exp_q.delete();
            aborted = 1'b1;
         end
         k++;
      end
   endtask

   task automatic halt_seq(input int id);
      for (int i = 0; i < 12; i++) begin
         ir = $urandom;
         cycle(obs_t'(0), $sformatf("i%0d_halt_c%0d", id, i));
      end
      reset = 1'b1;
      cycle(obs_t'(0), $sformatf("i%0d_halt_reset", id));
      reset = 1'b0;
      cycle(obs_t'(0), $sformatf("i%0d_rst_after_halt", id));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ab;
      logic [4:0]  op;
      logic [31:0] iv;
      int          r, abort_at;

      reset = 1'b1;
      @(posedge clk);
      #1;
      cycle(obs_t'(0), "reset_1");
      reset = 1'b0;
      cycle(obs_t'(0), "reset_2");

      do_instr(32'h489A8000, -1, 0, ab);                 // shl r1,r3,r5
      do_instr(32'h79200000, -1, 1, ab);                 // mul r2,r4
      do_instr(32'h08000000, -1, 2, ab);                 // unsupported opcode 1
      do_instr(32'hD0000000, -1, 3, ab);                 // nop
      do_instr(32'h80000000 | (32'd9 << 23) | (32'd14 << 19), -1, 4, ab);  // div r9,r14
      do_instr(32'h18000000 | (32'd7 << 23) | (32'd7 << 19) | (32'd7 << 15), -1, 5, ab);
      do_instr(32'h489A8000, 4, 6, ab);                  // reset during T4 of shl
      do_instr(32'h489A8000, -1, 7, ab);
      do_instr(32'hD8000000, -1, 8, ab);                 // halt
      halt_seq(8);

      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      op = 5'($urandom_range(3, 11));
         else if (r < 7) op = 5'($urandom_range(15, 16));
         else            op = 5'($urandom_range(0, 31));
         iv = {op, 27'($urandom)};
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
         do_instr(iv, abort_at, 100 + i, ab);
         if (!ab && op == 5'd27) halt_seq(100 + i);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
